// File: rtl/data_mem_responder.sv
// Load/store responder over a byte-addressable 64-bit word array, fixed LATENCY stall per request.
// Loads return the word shifted right by the byte offset; stores write only the addressed byte lanes.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_V,
    input  logic        REQ_WE,
    input  logic [1:0]  REQ_SIZE,
    input  logic [63:0] REQ_ADDR,
    input  logic [63:0] REQ_WDATA,
    input  logic        REQ_ADV,
    output logic        STALL,
    output logic [63:0] RDATA,
    output logic        RVALID,
    output logic        ERR
);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          cap, complete;

    logic          lat_we;
    logic [1:0]    lat_size;
    logic [63:0]   lat_addr, lat_wdata;

    logic [63:0]   mem [DEPTH_WORDS];

    // With LATENCY==1 the completion happens on the IDLE edge, before the latch is valid.
    logic          cur_we;
    logic [1:0]    cur_size;
    logic [63:0]   cur_addr, cur_wdata;
    assign cur_we    = (state == IDLE) ? REQ_WE    : lat_we;
    assign cur_size  = (state == IDLE) ? REQ_SIZE  : lat_size;
    assign cur_addr  = (state == IDLE) ? REQ_ADDR  : lat_addr;
    assign cur_wdata = (state == IDLE) ? REQ_WDATA : lat_wdata;

    logic [2:0]    off;
    logic [3:0]    nbytes;
    logic [60:0]   widx;
    logic [AW-1:0] idx;
    logic          misaligned, oor, bad;
    logic [7:0]    lane;
    logic [63:0]   wsh;

    assign off        = cur_addr[2:0];
    assign nbytes     = 4'd1 << cur_size;
    assign widx       = cur_addr[63:3];
    assign idx        = widx[AW-1:0];
    assign misaligned = ({1'b0, off} & (nbytes - 4'd1)) != 4'd0;
    assign oor        = widx >= 61'(DEPTH_WORDS);
    assign bad        = misaligned | oor;
    assign lane       = 8'((9'd1 << nbytes) - 9'd1) << off;
    assign wsh        = cur_wdata << {off, 3'b000};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap       = 1'b0;
        complete  = 1'b0;
        STALL     = 1'b0;
        case (state)
            IDLE: begin
                STALL = REQ_V;
                if (REQ_V) begin
                    cap = 1'b1;
                    if (LATENCY == 1) begin
                        complete  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                STALL = 1'b1;
                if (!REQ_V) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    complete  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                if (REQ_ADV) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            cnt    <= '0;
            RDATA  <= '0;
            RVALID <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (complete) begin
                RVALID <= 1'b1;
                ERR    <= bad;
                RDATA  <= (bad || cur_we) ? 64'd0 : (mem[idx] >> {off, 3'b000});
            end else if (state == DONE && REQ_ADV) begin
                RVALID <= 1'b0;
                ERR    <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (cap) begin
            lat_we    <= REQ_WE;
            lat_size  <= REQ_SIZE;
            lat_addr  <= REQ_ADDR;
            lat_wdata <= REQ_WDATA;
        end
    end

    // Array has no reset; a store only lands on its single completion edge.
    always_ff @(posedge CLK) begin
        if (!RESET && complete && cur_we && !bad) begin
            for (int b = 0; b < 8; b++) begin
                if (lane[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Random and directed load/store traffic checked against a byte-array reference model.
module tb_data_mem_responder;
    localparam int DEPTH = 16;
    localparam int LAT   = 3;

    logic        CLK = 1'b0;
    logic        RESET, REQ_V, REQ_WE, REQ_ADV;
    logic [1:0]  REQ_SIZE;
    logic [63:0] REQ_ADDR, REQ_WDATA;
    logic        STALL, RVALID, ERR;
    logic [63:0] RDATA;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] rmem [DEPTH*8];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLK(CLK), .RESET(RESET), .REQ_V(REQ_V), .REQ_WE(REQ_WE), .REQ_SIZE(REQ_SIZE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_ADV(REQ_ADV),
        .STALL(STALL), .RDATA(RDATA), .RVALID(RVALID), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model(input logic we, input logic [1:0] size, input logic [63:0] addr,
                         input logic [63:0] wdata, output logic bad, output logic [63:0] rdata);
        int unsigned off, nb, base;
        logic [63:0] word;
        off   = int'(addr % 8);
        nb    = 1 << size;
        bad   = ((off % nb) != 0) || ((addr / 8) >= DEPTH);
        rdata = '0;
        if (!bad) begin
            base = int'(addr) - off;
            if (we) begin
                for (int i = 0; i < int'(nb); i++) rmem[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < 8; i++) word[8*i +: 8] = rmem[base + i];
                rdata = word >> (8 * off);
            end
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] size, input logic [63:0] addr,
                        input logic [63:0] wdata, input int hold);
        logic        bad;
        logic [63:0] exp;
        int          n;
        model(we, size, addr, wdata, bad, exp);
        @(negedge CLK);
        REQ_V = 1'b1; REQ_WE = we; REQ_SIZE = size; REQ_ADDR = addr; REQ_WDATA = wdata;
        REQ_ADV = (hold == 0);
        n = 0;
        #1;
        while (STALL && n <= LAT + 5) begin
            n++;
            @(negedge CLK);
            #1;
        end
        chk("stall_cycles", 64'(n), 64'(LAT));
        chk("rvalid", {63'd0, RVALID}, 64'd1);
        chk("err", {63'd0, ERR}, {63'd0, bad});
        chk("rdata", RDATA, exp);
        for (int k = 0; k < hold; k++) begin
            @(negedge CLK);
            #1;
            chk("hold_rvalid", {63'd0, RVALID}, 64'd1);
            chk("hold_stall", {63'd0, STALL}, 64'd0);
            chk("hold_rdata", RDATA, exp);
        end
        REQ_ADV = 1'b1;
        @(negedge CLK);
        REQ_V = 1'b0; REQ_ADV = 1'b0;
        #1;
        chk("idle_stall", {63'd0, STALL}, 64'd0);
        chk("idle_rvalid", {63'd0, RVALID}, 64'd0);
        chk("idle_err", {63'd0, ERR}, 64'd0);
        chk("idle_rdata_held", RDATA, exp);
    endtask

    initial begin
        logic [63:0] addr;
        logic [7:0]  v;
        RESET = 1'b1; REQ_V = 1'b0; REQ_WE = 1'b0; REQ_ADV = 1'b0;
        REQ_SIZE = 2'd0; REQ_ADDR = '0; REQ_WDATA = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rst_rvalid", {63'd0, RVALID}, 64'd0);
        chk("rst_err", {63'd0, ERR}, 64'd0);
        chk("rst_rdata", RDATA, 64'd0);
        chk("rst_stall", {63'd0, STALL}, 64'd0);

        for (int w = 0; w < DEPTH; w++) xact(1'b1, 2'd3, 64'(w * 8), {$urandom, $urandom}, 0);

        xact(1'b1, 2'd3, 64'h10, 64'h1122334455667788, 0);
        xact(1'b0, 2'd3, 64'h10, 64'd0, 0);
        chk("dword_load_const", RDATA, 64'h1122334455667788);
        xact(1'b1, 2'd0, 64'h13, 64'hAB, 0);
        xact(1'b0, 2'd3, 64'h10, 64'd0, 0);
        chk("merged_const", RDATA, 64'h11223344AB667788);
        xact(1'b0, 2'd0, 64'h13, 64'd0, 0);
        chk("byte_load_const", RDATA, 64'h00000011223344AB);

        xact(1'b0, 2'd1, 64'h11, 64'd0, 0);
        xact(1'b1, 2'd2, 64'h1C, 64'hDEADBEEF, 0);
        xact(1'b1, 2'd2, 64'h1A, 64'hDEADBEEF, 0);
        xact(1'b0, 2'd3, 64'(DEPTH * 8), 64'd0, 0);
        xact(1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFF8, 64'h55, 0);
        xact(1'b0, 2'd3, 64'h18, 64'd0, 0);
        xact(1'b0, 2'd3, 64'(DEPTH * 8 - 8), 64'd0, 0);

        v = rmem[32];
        xact(1'b1, 2'd0, 64'h20, {56'd0, v + 8'd1}, 4);
        xact(1'b0, 2'd0, 64'h20, 64'd0, 0);

        // Store abandoned mid-flight by dropping the request.
        @(negedge CLK);
        REQ_V = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'd3; REQ_ADDR = 64'h28; REQ_WDATA = 64'hCAFE;
        REQ_ADV = 1'b1;
        @(negedge CLK);
        REQ_V = 1'b0;
        @(negedge CLK);
        #1;
        chk("flush_stall", {63'd0, STALL}, 64'd0);
        chk("flush_rvalid", {63'd0, RVALID}, 64'd0);
        xact(1'b0, 2'd3, 64'h28, 64'd0, 0);

        // Reset while a store is pending.
        @(negedge CLK);
        REQ_V = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'd3; REQ_ADDR = 64'h30; REQ_WDATA = 64'hBEEF;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0; REQ_V = 1'b0;
        #1;
        chk("midrst_rvalid", {63'd0, RVALID}, 64'd0);
        chk("midrst_err", {63'd0, ERR}, 64'd0);
        chk("midrst_stall_lo", {63'd0, STALL}, 64'd0);
        chk("midrst_rdata", RDATA, 64'd0);
        REQ_V = 1'b1;
        #1;
        chk("midrst_stall_hi", {63'd0, STALL}, 64'd1);
        REQ_V = 1'b0;
        xact(1'b0, 2'd3, 64'h30, 64'd0, 0);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 9) == 0) addr = {$urandom, $urandom};
            else addr = 64'($urandom_range(0, DEPTH * 8 + 15));
            xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), addr,
                 {$urandom, $urandom}, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
